// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide controller.
//   md_op_e     : E-stage mult/div operation encoding
//   md_state_e  : controller FSM states
//   MULT_CYCLES_DEF / DIV_CYCLES_DEF : default busy lengths
//   is_mul_div / is_div_op : operation class helpers
package mult_div_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // True for the four operations that occupy the unit for several cycles.
    function automatic logic is_mul_div(input md_op_e op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // True for the two divide flavours.
    function automatic logic is_div_op(input md_op_e op);
        case (op)
            MD_DIV, MD_DIVU: return 1'b1;
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mult_div_ctrl_md_arith.sv
// Purely combinational multiply/divide datapath.
//   op          in  latched operation (mult/multu/div/divu; others give 0)
//   a, b        in  latched rs / rt operands
//   res_hi      out HI result (product high word or remainder)
//   res_lo      out LO result (product low word or quotient)
//   div_by_zero out divisor is zero; caller must suppress the write-back
module md_arith
    import mult_div_ctrl_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic [63:0] a_ext_s;
    logic [63:0] b_ext_s;
    logic [63:0] prod_s;
    logic        signed_div_s;
    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [31:0] b_safe_s;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic        overflow_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;

    // Product: sign- or zero-extend to 64 bits so one unsigned multiplier
    // yields the correct low 64 bits for both mult and multu.
    always_comb begin
        a_ext_s = {32'd0, a};
        b_ext_s = {32'd0, b};
        if (op == MD_MULT) begin
            a_ext_s = {{32{a[31]}}, a};
            b_ext_s = {{32{b[31]}}, b};
        end else begin
            a_ext_s = {32'd0, a};
            b_ext_s = {32'd0, b};
        end
        prod_s = a_ext_s * b_ext_s;
    end

    // Quotient/remainder: divide magnitudes, then restore signs. Quotient is
    // truncated toward zero, remainder takes the dividend's sign.
    always_comb begin
        signed_div_s = (op == MD_DIV);
        a_neg_s      = signed_div_s & a[31];
        b_neg_s      = signed_div_s & b[31];
        a_mag_s      = a_neg_s ? (32'd0 - a) : a;
        b_mag_s      = b_neg_s ? (32'd0 - b) : b;
        div_by_zero  = (b == 32'd0);
        // Substitute 1 for a zero divisor so the divider never sees 0;
        // the result is discarded by the caller in that case.
        b_safe_s     = div_by_zero ? 32'd1 : b_mag_s;
        uq_s         = a_mag_s / b_safe_s;
        ur_s         = a_mag_s % b_safe_s;
        overflow_s   = signed_div_s & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
        if (overflow_s) begin
            // Most-negative / -1 cannot be represented; wrap to the dividend.
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else begin
            quot_s = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
            rem_s  = a_neg_s ? (32'd0 - ur_s) : ur_s;
        end
    end

    // Route the result that matches the operation onto HI/LO.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT, MD_MULTU: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_DIV, MD_DIVU: begin
                res_hi = rem_s;
                res_lo = quot_s;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// E-stage multiply/divide controller owning the HI/LO registers.
//   clk, reset  in  clock, synchronous active-high reset
//   md_op       in  E-stage operation (see md_op_e)
//   rs_val      in  forwarded rs (multiplicand/dividend, mthi/mtlo source)
//   rt_val      in  forwarded rt (multiplier/divisor)
//   d_is_md     in  D-stage instruction touches the mult/div unit or HI/LO
//   start       out a mult/div is accepted this cycle (combinational)
//   busy        out operation in flight (registered)
//   stall       out stall request to the hazard unit (combinational)
//   hi, lo      out HI/LO registers
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    md_op_e           op_q,    op_d;
    logic [31:0]      a_q,     a_d;
    logic [31:0]      b_q,     b_d;
    logic [31:0]      hi_q,    hi_d;
    logic [31:0]      lo_q,    lo_d;

    md_op_e      md_op_s;
    logic        busy_s;
    logic        start_s;
    logic [31:0] res_hi_s;
    logic [31:0] res_lo_s;
    logic        div_by_zero_s;
    logic        res_wr_s;

    assign md_op_s = md_op_e'(md_op);
    assign busy_s  = (state_q == ST_RUN);

    md_arith u_md_arith (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .res_hi      (res_hi_s),
        .res_lo      (res_lo_s),
        .div_by_zero (div_by_zero_s)
    );

    // A zero-divisor divide runs its full length but leaves HI/LO alone.
    assign res_wr_s = is_div_op(op_q) ? ~div_by_zero_s : 1'b1;

    // Next-state, counter, operand latch and HI/LO update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        start_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_mul_div(md_op_s)) begin
                    start_s = 1'b1;
                    state_d = ST_RUN;
                    op_d    = md_op_s;
                    a_d     = rs_val;
                    b_d     = rt_val;
                    cnt_d   = is_div_op(md_op_s) ? DIV_LOAD : MULT_LOAD;
                end else if (md_op_s == MD_MTHI) begin
                    hi_d = rs_val;
                end else if (md_op_s == MD_MTLO) begin
                    lo_d = rs_val;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Everything on md_op is ignored here; the stall keeps the
                // pipeline from issuing anything in a correct program.
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    if (res_wr_s) begin
                        hi_d = res_hi_s;
                        lo_d = res_lo_s;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter, operand and HI/LO registers; reset beats completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            op_q    <= MD_NONE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign start = start_s;
    assign busy  = busy_s;
    assign stall = d_is_md & (start_s | busy_s);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
